// File: rtl/fpu_mds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mds_pkg
// Description : Shared codes, constants and FSM encoding for the FPU
//               multiply/divide/sqrt issue sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_mds_pkg;

    // Operation codes
    localparam logic [1:0] OP_MUL     = 2'b00;
    localparam logic [1:0] OP_DIV     = 2'b01;
    localparam logic [1:0] OP_SQRT    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // Rounding-mode codes
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    // Single-precision constants
    localparam logic [31:0] ONE_F32      = 32'h3F80_0000;
    localparam logic [31:0] QNAN_F32     = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } mds_state_t;

    // Dynamic rounding mode defers to the CSR value
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] csr_frm);
        return (rm == RM_DYN) ? csr_frm : rm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_operand_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fpu_operand_unpack
// Description : Combinational single-precision field splitter and classifier.
//               Subnormals keep exponent 0 and are not normalised here.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_operand_unpack
    import fpu_mds_pkg::*;
(
    input  logic [31:0] f,
    output logic        sign,
    output logic [7:0]  exponent,
    output logic [23:0] sig,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_quiet
);

    logic w_exp_zero;
    logic w_exp_max;
    logic w_mant_nz;

    assign w_exp_zero = (f[30:23] == 8'h00);
    assign w_exp_max  = (f[30:23] == EXP_ALL_ONES);
    assign w_mant_nz  = |f[22:0];

    assign sign     = f[31];
    assign exponent = f[30:23];
    assign sig      = {!w_exp_zero, f[22:0]};
    assign is_zero  = w_exp_zero && !w_mant_nz;
    assign is_inf   = w_exp_max && !w_mant_nz;
    assign is_nan   = w_exp_max && w_mant_nz;
    assign is_quiet = f[22];

endmodule
`default_nettype wire

// File: rtl/fpu_mds_issue.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mds_issue
// Description : Request/response sequencer in front of the FPU mul/div/sqrt
//               unit. Registers unpacked operands, starts the unit, waits for
//               completion and returns result plus exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_mds_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [2:0]       frm,
    output logic             mds_start,
    output logic [1:0]       mds_op,
    output logic [2:0]       rounding_mode,
    output logic             sign_A,
    output logic             sign_B,
    output logic [7:0]       exp_A,
    output logic [7:0]       exp_B,
    output logic [23:0]      sig_A,
    output logic [23:0]      sig_B,
    output logic             isZeroA,
    output logic             isZeroB,
    output logic             isInfA,
    output logic             isInfB,
    output logic             isNaNA,
    output logic             isNaNB,
    output logic             isSignaling,
    output logic             subnormal_sqrt_in,
    input  logic [31:0]      mds_out,
    input  logic             mds_done,
    input  logic             mds_of,
    input  logic             mds_uf,
    input  logic             mds_nv,
    input  logic             mds_nx,
    input  logic             mds_dz,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [4:0]       rsp_fflags,
    output logic             rsp_illegal,
    output logic             busy
);

    import fpu_mds_pkg::*;

    mds_state_t  r_state;

    logic [31:0] w_b_src;
    logic        w_a_sign, w_b_sign;
    logic [7:0]  w_a_exp, w_b_exp;
    logic [23:0] w_a_sig, w_b_sig;
    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf;
    logic        w_a_nan, w_b_nan, w_a_quiet, w_b_quiet;
    logic [2:0]  w_rm;
    logic        w_legal;
    logic        w_accept;
    logic        w_signaling;
    logic        w_sub_sqrt;
    logic [4:0]  w_flags;

    // Sqrt has no second operand; feed the unit a harmless 1.0 instead
    assign w_b_src = (req_op == OP_SQRT) ? ONE_F32 : req_b;

    fpu_operand_unpack u_unpack_a (
        .f        (req_a),
        .sign     (w_a_sign),
        .exponent (w_a_exp),
        .sig      (w_a_sig),
        .is_zero  (w_a_zero),
        .is_inf   (w_a_inf),
        .is_nan   (w_a_nan),
        .is_quiet (w_a_quiet)
    );

    fpu_operand_unpack u_unpack_b (
        .f        (w_b_src),
        .sign     (w_b_sign),
        .exponent (w_b_exp),
        .sig      (w_b_sig),
        .is_zero  (w_b_zero),
        .is_inf   (w_b_inf),
        .is_nan   (w_b_nan),
        .is_quiet (w_b_quiet)
    );

    assign w_rm        = resolve_rm(req_rm, frm);
    assign w_legal     = (req_op != OP_ILLEGAL) && (w_rm <= RM_RMM);
    assign w_accept    = req_valid && req_ready;
    assign w_signaling = (w_a_nan && !w_a_quiet) ||
                         ((req_op != OP_SQRT) && w_b_nan && !w_b_quiet);
    assign w_sub_sqrt  = (req_op == OP_SQRT) && (w_a_exp == 8'h00) && (|req_a[22:0]);

    always_comb begin
        w_flags        = 5'b0_0000;
        w_flags[FF_NV] = mds_nv;
        w_flags[FF_DZ] = mds_dz;
        w_flags[FF_OF] = mds_of;
        w_flags[FF_UF] = mds_uf;
        w_flags[FF_NX] = mds_nx;
    end

    assign req_ready = (r_state == ST_IDLE) && !flush;
    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);

    // Operand/mode capture: only a legal accept updates them, so they stay frozen while the unit runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mds_op            <= 2'b00;
            rounding_mode     <= 3'b000;
            sign_A            <= 1'b0;
            sign_B            <= 1'b0;
            exp_A             <= 8'h00;
            exp_B             <= 8'h00;
            sig_A             <= 24'h00_0000;
            sig_B             <= 24'h00_0000;
            isZeroA           <= 1'b0;
            isZeroB           <= 1'b0;
            isInfA            <= 1'b0;
            isInfB            <= 1'b0;
            isNaNA            <= 1'b0;
            isNaNB            <= 1'b0;
            isSignaling       <= 1'b0;
            subnormal_sqrt_in <= 1'b0;
        end else if (w_accept && w_legal) begin
            mds_op            <= req_op;
            rounding_mode     <= w_rm;
            sign_A            <= w_a_sign;
            sign_B            <= w_b_sign;
            exp_A             <= w_a_exp;
            exp_B             <= w_b_exp;
            sig_A             <= w_a_sig;
            sig_B             <= w_b_sig;
            isZeroA           <= w_a_zero;
            isZeroB           <= w_b_zero;
            isInfA            <= w_a_inf;
            isInfB            <= w_b_inf;
            isNaNA            <= w_a_nan;
            isNaNB            <= w_b_nan;
            isSignaling       <= w_signaling;
            subnormal_sqrt_in <= w_sub_sqrt;
        end
    end

    // Sequencer: issue, wait for done (or drain after flush), hold response until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            mds_start   <= 1'b0;
            rsp_data    <= 32'h0000_0000;
            rsp_tag     <= '0;
            rsp_fflags  <= 5'b0_0000;
            rsp_illegal <= 1'b0;
        end else begin
            mds_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        rsp_tag <= req_tag;
                        if (w_legal) begin
                            r_state   <= ST_ISSUE;
                            mds_start <= 1'b1;
                        end else begin
                            r_state     <= ST_RESP;
                            rsp_illegal <= 1'b1;
                            rsp_data    <= 32'h0000_0000;
                            rsp_fflags  <= 5'b0_0000;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    // A done coinciding with flush already retires the op, so skip DRAIN then
                    if (flush) begin
                        r_state <= mds_done ? ST_IDLE : ST_DRAIN;
                    end else if (mds_done) begin
                        r_state     <= ST_RESP;
                        rsp_data    <= mds_out;
                        rsp_fflags  <= w_flags;
                        rsp_illegal <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (mds_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (flush || rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_mds_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_mds_issue
// Description : Directed self-checking bench for fpu_mds_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_mds_issue;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a, req_b;
    logic [1:0]       req_op;
    logic [2:0]       req_rm;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       frm;
    logic             mds_start;
    logic [1:0]       mds_op;
    logic [2:0]       rounding_mode;
    logic             sign_A, sign_B;
    logic [7:0]       exp_A, exp_B;
    logic [23:0]      sig_A, sig_B;
    logic             isZeroA, isZeroB, isInfA, isInfB, isNaNA, isNaNB;
    logic             isSignaling, subnormal_sqrt_in;
    logic [31:0]      mds_out;
    logic             mds_done, mds_of, mds_uf, mds_nv, mds_nx, mds_dz;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic [4:0]       rsp_fflags;
    logic             rsp_illegal;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_mds_issue #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rm(req_rm),
        .req_tag(req_tag), .frm(frm),
        .mds_start(mds_start), .mds_op(mds_op), .rounding_mode(rounding_mode),
        .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B),
        .sig_A(sig_A), .sig_B(sig_B),
        .isZeroA(isZeroA), .isZeroB(isZeroB), .isInfA(isInfA), .isInfB(isInfB),
        .isNaNA(isNaNA), .isNaNB(isNaNB), .isSignaling(isSignaling),
        .subnormal_sqrt_in(subnormal_sqrt_in),
        .mds_out(mds_out), .mds_done(mds_done),
        .mds_of(mds_of), .mds_uf(mds_uf), .mds_nv(mds_nv), .mds_nx(mds_nx), .mds_dz(mds_dz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_fflags(rsp_fflags), .rsp_illegal(rsp_illegal),
        .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [2:0] rm, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_rm    = rm;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    // Unit model: pulse done for one cycle with the given result and flags {nv,dz,of,uf,nx}
    task automatic unit_done(input logic [31:0] res, input logic [4:0] fl);
        mds_done = 1'b1;
        mds_out  = res;
        mds_nv   = fl[4];
        mds_dz   = fl[3];
        mds_of   = fl[2];
        mds_uf   = fl[1];
        mds_nx   = fl[0];
        tick();
        mds_done = 1'b0;
        {mds_nv, mds_dz, mds_of, mds_uf, mds_nx} = 5'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
        req_a = 32'h0; req_b = 32'h0; req_op = 2'b00; req_rm = 3'b000; req_tag = '0;
        frm = 3'b000; mds_out = 32'h0; mds_done = 1'b0;
        {mds_nv, mds_dz, mds_of, mds_uf, mds_nx} = 5'b0;
        rsp_ready = 1'b0;
        tick(); tick();

        // Reset state
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_start",     32'(mds_start), 32'd0);
        check_eq("rst_isZeroA",   32'(isZeroA),   32'd0);
        check_eq("rst_sig_B",     32'(sig_B),     32'd0);
        reset = 1'b0;
        tick();

        // Multiply 2.0 x 3.0, done three cycles after start
        issue(32'h4000_0000, 32'h4040_0000, 2'b00, 3'b000, 5'd5);
        check_eq("mul_start",  32'(mds_start), 32'd1);
        check_eq("mul_exp_A",  32'(exp_A),     32'h80);
        check_eq("mul_sig_A",  32'(sig_A),     32'h80_0000);
        check_eq("mul_exp_B",  32'(exp_B),     32'h80);
        check_eq("mul_sig_B",  32'(sig_B),     32'hC0_0000);
        check_eq("mul_sign_A", 32'(sign_A),    32'd0);
        check_eq("mul_op",     32'(mds_op),    32'd0);
        tick();
        check_eq("mul_start_one_cycle", 32'(mds_start), 32'd0);
        tick();
        check_eq("mul_no_early_valid", 32'(rsp_valid), 32'd0);
        unit_done(32'h40C0_0000, 5'b00000);
        check_eq("mul_rsp_valid", 32'(rsp_valid),   32'd1);
        check_eq("mul_rsp_data",  rsp_data,         32'h40C0_0000);
        check_eq("mul_rsp_tag",   32'(rsp_tag),     32'd5);
        check_eq("mul_fflags",    32'(rsp_fflags),  32'd0);
        check_eq("mul_illegal",   32'(rsp_illegal), 32'd0);
        take_rsp();
        check_eq("mul_idle_valid", 32'(rsp_valid), 32'd0);
        check_eq("mul_idle_ready", 32'(req_ready), 32'd1);

        // Sqrt of smallest subnormal; B forced to 1.0
        issue(32'h0000_0001, 32'hDEAD_BEEF, 2'b10, 3'b001, 5'd3);
        check_eq("sqrt_subn_flag", 32'(subnormal_sqrt_in), 32'd1);
        check_eq("sqrt_sig_A",     32'(sig_A),   32'h00_0001);
        check_eq("sqrt_exp_A",     32'(exp_A),   32'h00);
        check_eq("sqrt_isZeroA",   32'(isZeroA), 32'd0);
        check_eq("sqrt_exp_B",     32'(exp_B),   32'h7F);
        check_eq("sqrt_sig_B",     32'(sig_B),   32'h80_0000);
        check_eq("sqrt_isZeroB",   32'(isZeroB), 32'd0);
        check_eq("sqrt_isInfB",    32'(isInfB),  32'd0);
        check_eq("sqrt_rm",        32'(rounding_mode), 32'd1);
        check_eq("sqrt_op",        32'(mds_op),  32'd2);
        tick();
        unit_done(32'h1A35_04F3, 5'b00001);
        check_eq("sqrt_rsp_data", rsp_data,        32'h1A35_04F3);
        check_eq("sqrt_fflags",   32'(rsp_fflags), 32'h01);
        take_rsp();

        // Signaling NaN multiply
        issue(32'h7F80_0001, 32'h4000_0000, 2'b00, 3'b000, 5'd7);
        check_eq("snan_isNaNA",  32'(isNaNA),      32'd1);
        check_eq("snan_isInfA",  32'(isInfA),      32'd0);
        check_eq("snan_isNaNB",  32'(isNaNB),      32'd0);
        check_eq("snan_signal",  32'(isSignaling), 32'd1);
        unit_done(32'h7FC0_0000, 5'b10000);
        check_eq("snan_fflags",  32'(rsp_fflags),  32'h10);
        check_eq("snan_data",    rsp_data,         32'h7FC0_0000);
        take_rsp();

        // Divide -1.0 / 0 with dynamic rounding mode from frm
        frm = 3'b010;
        issue(32'hBF80_0000, 32'h0000_0000, 2'b01, 3'b111, 5'd9);
        check_eq("dyn_rm",       32'(rounding_mode), 32'd2);
        check_eq("div_op",       32'(mds_op),        32'd1);
        check_eq("div_sign_A",   32'(sign_A),        32'd1);
        check_eq("div_sign_B",   32'(sign_B),        32'd0);
        check_eq("div_isZeroB",  32'(isZeroB),       32'd1);
        check_eq("div_signal",   32'(isSignaling),   32'd0);
        unit_done(32'hFF80_0000, 5'b01000);
        check_eq("div_fflags",   32'(rsp_fflags),    32'h08);
        check_eq("div_tag",      32'(rsp_tag),       32'd9);
        take_rsp();
        frm = 3'b000;

        // Illegal static rounding mode 101
        issue(32'h3F80_0000, 32'h3F80_0000, 2'b00, 3'b101, 5'd2);
        check_eq("ill_rm_valid",  32'(rsp_valid),   32'd1);
        check_eq("ill_rm_flag",   32'(rsp_illegal), 32'd1);
        check_eq("ill_rm_start",  32'(mds_start),   32'd0);
        check_eq("ill_rm_data",   rsp_data,         32'h0);
        check_eq("ill_rm_fflags", 32'(rsp_fflags),  32'd0);
        take_rsp();

        // Illegal dynamic mode (frm = 101)
        frm = 3'b101;
        issue(32'h3F80_0000, 32'h3F80_0000, 2'b01, 3'b111, 5'd4);
        check_eq("ill_frm_flag",  32'(rsp_illegal), 32'd1);
        check_eq("ill_frm_start", 32'(mds_start),   32'd0);
        take_rsp();
        frm = 3'b000;

        // Illegal op code 11
        issue(32'h3F80_0000, 32'h3F80_0000, 2'b11, 3'b000, 5'd6);
        check_eq("ill_op_valid", 32'(rsp_valid),   32'd1);
        check_eq("ill_op_flag",  32'(rsp_illegal), 32'd1);
        take_rsp();

        // Flush in IDLE blocks acceptance
        req_valid = 1'b1; flush = 1'b1;
        #1;
        check_eq("flush_idle_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check_eq("flush_idle_busy", 32'(busy), 32'd0);

        // Flush in WAIT: drain the result silently
        issue(32'h4000_0000, 32'h4000_0000, 2'b00, 3'b000, 5'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("drain_busy",  32'(busy),      32'd1);
        check_eq("drain_ready", 32'(req_ready), 32'd0);
        tick();
        unit_done(32'h4080_0000, 5'b00000);
        check_eq("drain_no_valid", 32'(rsp_valid), 32'd0);
        check_eq("drain_ready_after", 32'(req_ready), 32'd1);
        check_eq("drain_idle", 32'(busy), 32'd0);

        // Done in the ISSUE cycle
        issue(32'h3F80_0000, 32'h3F80_0000, 2'b00, 3'b000, 5'd11);
        unit_done(32'h1234_5678, 5'b00001);
        check_eq("zlat_valid",   32'(rsp_valid),   32'd1);
        check_eq("zlat_data",    rsp_data,         32'h1234_5678);
        check_eq("zlat_fflags",  32'(rsp_fflags),  32'h01);
        check_eq("zlat_illegal", 32'(rsp_illegal), 32'd0);
        check_eq("zlat_tag",     32'(rsp_tag),     32'd11);

        // Backpressure: response held for 5 cycles, new request not accepted
        req_valid = 1'b1; req_a = 32'h4000_0000; req_tag = 5'd20;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_data",  rsp_data,       32'h1234_5678);
            check_eq("bp_tag",   32'(rsp_tag),   32'd11);
            check_eq("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        take_rsp();
        check_eq("bp_released", 32'(busy), 32'd0);

        // Asynchronous reset mid-WAIT
        issue(32'h4000_0000, 32'h0, 2'b10, 3'b100, 5'd1);
        tick();
        check_eq("prerst_op", 32'(mds_op),        32'd2);
        check_eq("prerst_rm", 32'(rounding_mode), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_busy",  32'(busy),          32'd0);
        check_eq("arst_op",    32'(mds_op),        32'd0);
        check_eq("arst_rm",    32'(rounding_mode), 32'd0);
        check_eq("arst_exp_A", 32'(exp_A),         32'd0);
        check_eq("arst_sig_B", 32'(sig_B),         32'd0);
        check_eq("arst_valid", 32'(rsp_valid),     32'd0);
        check_eq("arst_ready", 32'(req_ready),     32'd1);
        tick();
        reset = 1'b0;
        tick();

        // Stray done in IDLE is ignored
        unit_done(32'hFFFF_FFFF, 5'b11111);
        check_eq("stray_valid", 32'(rsp_valid), 32'd0);
        check_eq("stray_busy",  32'(busy),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
